ifetch_unit: RTL and testbench



---
 rtl/ifetch_unit.sv | 150 +++++++++++++++
 tb/tb_ifetch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_unit
//  Description : Instruction fetch stage feeding the vector execution unit.
//                Reads 64-bit opcode pairs from instruction memory with a
//                single outstanding request, issues them on opcode_vld with
//                back-pressure from inst_buff_full, and supports flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_unit #(
    parameter int          ADDR_W   = 32,
    parameter int          CNT_W    = 16,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic [CNT_W-1:0]  inst_count,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rsp_vld,
    input  logic [63:0]       imem_rsp_data,
    output logic              opcode_vld,
    output logic [31:0]       opcode0,
    output logic [31:0]       opcode1,
    input  logic              inst_buff_full,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ISSUE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [CNT_W-1:0]    r_remaining;
    logic                r_outstanding;
    logic [63:0]         r_data;
    logic                r_zero_done;

    logic                w_start_ok;
    logic                w_issue;
    logic                w_last;
    logic                w_gnt_ok;
    logic                w_rsp_take;
    logic                w_unused_pc_lsb;

    // Byte offset within the 8-byte fetch granule is irrelevant.
    assign w_unused_pc_lsb = ^start_pc[2:0];

    assign w_start_ok = (r_state == ST_IDLE) && start && !flush;
    // A response only counts while a request is in flight; in any state other
    // than WAIT it is the stale answer to a flushed request and is dropped.
    assign w_rsp_take = imem_rsp_vld && r_outstanding;
    assign w_gnt_ok   = imem_req && imem_gnt;
    assign w_last     = (r_remaining <= CNT_W'(2));

    // Next-state and output decode
    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        imem_addr   = '0;
        opcode_vld  = 1'b0;
        opcode0     = 32'h0;
        opcode1     = 32'h0;
        w_issue     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start && (inst_count != '0))
                    w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                // Hold the request back until any stale response is drained.
                imem_req  = !r_outstanding && !flush;
                imem_addr = imem_req ? r_pc : '0;
                if (w_gnt_ok)
                    w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_rsp_take)
                    w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_issue    = !inst_buff_full && !flush;
                opcode_vld = w_issue;
                opcode0    = r_data[31:0];
                opcode1    = (r_remaining >= CNT_W'(2)) ? r_data[63:32] : NOP_WORD;
                if (w_issue)
                    w_state_nxt = w_last ? ST_IDLE : ST_REQ;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (flush)
            w_state_nxt = ST_IDLE;
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (w_issue && w_last) || r_zero_done;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Program counter, remaining count, outstanding flag and pair register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= '0;
            r_remaining   <= '0;
            r_outstanding <= 1'b0;
            r_data        <= '0;
            r_zero_done   <= 1'b0;
        end else begin
            r_zero_done <= w_start_ok && (inst_count == '0);

            if (w_start_ok && (inst_count != '0)) begin
                r_pc        <= {start_pc[ADDR_W-1:3], 3'b000};
                r_remaining <= inst_count;
            end

            if (w_gnt_ok)
                r_outstanding <= 1'b1;
            else if (w_rsp_take)
                r_outstanding <= 1'b0;

            if ((r_state == ST_WAIT) && w_rsp_take)
                r_data <= imem_rsp_data;

            if (w_issue) begin
                r_remaining <= w_last ? '0 : (r_remaining - CNT_W'(2));
                r_pc        <= r_pc + ADDR_W'(8);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifetch_unit
//  Description : Directed self-checking bench for ifetch_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

    localparam logic [63:0] c_w100 = 64'hB000_0104_A000_0100;
    localparam logic [63:0] c_w108 = 64'hB000_010C_A000_0108;
    localparam logic [63:0] c_w200 = 64'hB000_0204_A000_0200;
    localparam logic [63:0] c_stale = 64'hDEAD_BEEF_DEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] start_pc;
    logic [15:0] inst_count;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rsp_vld;
    logic [63:0] imem_rsp_data;
    logic        opcode_vld;
    logic [31:0] opcode0;
    logic [31:0] opcode1;
    logic        inst_buff_full;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ifetch_unit #(
        .ADDR_W   (32),
        .CNT_W    (16),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .start_pc       (start_pc),
        .inst_count     (inst_count),
        .flush          (flush),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rsp_vld   (imem_rsp_vld),
        .imem_rsp_data  (imem_rsp_data),
        .opcode_vld     (opcode_vld),
        .opcode0        (opcode0),
        .opcode1        (opcode1),
        .inst_buff_full (inst_buff_full),
        .busy           (busy),
        .done           (done)
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called while in REQ: hold off gnt for gnt_wait cycles, grant, then
    // return the response one cycle later. Returns with the DUT in ISSUE.
    task automatic serve(input logic [31:0] addr, input int gnt_wait, input logic [63:0] data);
        for (int i = 0; i < gnt_wait; i++) begin
            chk_eq("req_hold", 64'(imem_req), 64'd1);
            chk_eq("addr_hold", 64'(imem_addr), 64'(addr));
            imem_gnt = 1'b0;
            tick();
        end
        chk_eq("req", 64'(imem_req), 64'd1);
        chk_eq("addr", 64'(imem_addr), 64'(addr));
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk_eq("req_wait", 64'(imem_req), 64'd0);
        imem_rsp_vld  = 1'b1;
        imem_rsp_data = data;
        tick();
        imem_rsp_vld  = 1'b0;
        imem_rsp_data = '0;
    endtask

    task automatic do_start(input logic [31:0] pc, input logic [15:0] cnt);
        start      = 1'b1;
        start_pc   = pc;
        inst_count = cnt;
        tick();
        start      = 1'b0;
    endtask

    task automatic chk_issue(input string tag, input logic [31:0] o0, input logic [31:0] o1, input logic d);
        chk_eq({tag, "_vld"}, 64'(opcode_vld), 64'd1);
        chk_eq({tag, "_op0"}, 64'(opcode0), 64'(o0));
        chk_eq({tag, "_op1"}, 64'(opcode1), 64'(o1));
        chk_eq({tag, "_done"}, 64'(done), 64'(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; start_pc = '0; inst_count = '0; flush = 1'b0;
        imem_gnt = 1'b0; imem_rsp_vld = 1'b0; imem_rsp_data = '0; inst_buff_full = 1'b0;
        tick(); tick();
        chk_eq("rst_req", 64'(imem_req), 64'd0);
        chk_eq("rst_busy", 64'(busy), 64'd0);
        chk_eq("rst_vld", 64'(opcode_vld), 64'd0);
        chk_eq("rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        tick();

        // 1: four instructions, two full pairs
        do_start(32'h100, 16'd4);
        chk_eq("t1_busy", 64'(busy), 64'd1);
        serve(32'h100, 0, c_w100);
        chk_issue("t1_p0", 32'hA000_0100, 32'hB000_0104, 1'b0);
        tick();
        serve(32'h108, 0, c_w108);
        chk_issue("t1_p1", 32'hA000_0108, 32'hB000_010C, 1'b1);
        tick();
        chk_eq("t1_busy_end", 64'(busy), 64'd0);
        chk_eq("t1_vld_end", 64'(opcode_vld), 64'd0);
        chk_eq("t1_done_end", 64'(done), 64'd0);

        // 2: odd count, unaligned start address
        do_start(32'h105, 16'd3);
        serve(32'h100, 0, c_w100);
        chk_issue("t2_p0", 32'hA000_0100, 32'hB000_0104, 1'b0);
        tick();
        serve(32'h108, 0, c_w108);
        chk_issue("t2_p1", 32'hA000_0108, 32'h0000_0000, 1'b1);
        tick();
        chk_eq("t2_busy_end", 64'(busy), 64'd0);

        // 3: back-pressure for 10 cycles in ISSUE
        do_start(32'h100, 16'd2);
        inst_buff_full = 1'b1;
        serve(32'h100, 0, c_w100);
        for (int i = 0; i < 10; i++) begin
            chk_eq("t3_vld_stall", 64'(opcode_vld), 64'd0);
            chk_eq("t3_op0_stall", 64'(opcode0), 64'hA000_0100);
            chk_eq("t3_op1_stall", 64'(opcode1), 64'hB000_0104);
            chk_eq("t3_done_stall", 64'(done), 64'd0);
            tick();
        end
        inst_buff_full = 1'b0;
        #1;
        chk_issue("t3_rel", 32'hA000_0100, 32'hB000_0104, 1'b1);
        tick();
        chk_eq("t3_vld_once", 64'(opcode_vld), 64'd0);
        chk_eq("t3_busy_end", 64'(busy), 64'd0);

        // 4: grant delayed 5 cycles
        do_start(32'h108, 16'd1);
        serve(32'h108, 5, c_w108);
        chk_issue("t4", 32'hA000_0108, 32'h0000_0000, 1'b1);
        tick();
        chk_eq("t4_req_end", 64'(imem_req), 64'd0);

        // 5: flush in WAIT, restart, stale response discarded
        do_start(32'h300, 16'd2);
        chk_eq("t5_req", 64'(imem_req), 64'd1);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_eq("t5_flush_busy", 64'(busy), 64'd0);
        chk_eq("t5_flush_done", 64'(done), 64'd0);
        do_start(32'h200, 16'd2);
        for (int i = 0; i < 2; i++) begin
            chk_eq("t5_busy", 64'(busy), 64'd1);
            chk_eq("t5_req_blocked", 64'(imem_req), 64'd0);
            tick();
        end
        imem_rsp_vld  = 1'b1;
        imem_rsp_data = c_stale;
        #1;
        chk_eq("t5_req_stale", 64'(imem_req), 64'd0);
        tick();
        imem_rsp_vld  = 1'b0;
        imem_rsp_data = '0;
        chk_eq("t5_vld_stale", 64'(opcode_vld), 64'd0);
        serve(32'h200, 0, c_w200);
        chk_issue("t5", 32'hA000_0200, 32'hB000_0204, 1'b1);
        tick();

        // 6a: zero-length program
        do_start(32'h400, 16'd0);
        chk_eq("t6_done", 64'(done), 64'd1);
        chk_eq("t6_busy", 64'(busy), 64'd0);
        chk_eq("t6_req", 64'(imem_req), 64'd0);
        tick();
        chk_eq("t6_done_once", 64'(done), 64'd0);
        chk_eq("t6_req2", 64'(imem_req), 64'd0);

        // 6b: asynchronous reset while issuing
        do_start(32'h100, 16'd4);
        serve(32'h100, 0, c_w100);
        chk_issue("t6_pre", 32'hA000_0100, 32'hB000_0104, 1'b0);
        reset = 1'b1;
        #1;
        chk_eq("t6_rst_vld", 64'(opcode_vld), 64'd0);
        chk_eq("t6_rst_op0", 64'(opcode0), 64'd0);
        chk_eq("t6_rst_op1", 64'(opcode1), 64'd0);
        chk_eq("t6_rst_busy", 64'(busy), 64'd0);
        chk_eq("t6_rst_done", 64'(done), 64'd0);
        chk_eq("t6_rst_req", 64'(imem_req), 64'd0);
        chk_eq("t6_rst_addr", 64'(imem_addr), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
